// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART baud generator slice.
package uart_pkg;

  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_FRAC_WIDTH = 4;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } baud_state_e;

  // Width needed to hold a counter running 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_os_prescaler.sv
// Oversample counter: advances once per os_tick, flags the bit centre
// (count reaching OVERSAMPLE/2) and the bit boundary (wrap to 0).
module uart_os_prescaler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);

  logic [CNT_W-1:0] os_cnt_r;
  logic [CNT_W-1:0] os_cnt_s;
  logic             mid_tick_r;
  logic             mid_tick_s;
  logic             bit_tick_r;
  logic             bit_tick_s;

  // Next count and tick flags; clear wins over advance.
  always_comb begin
    os_cnt_s   = os_cnt_r;
    mid_tick_s = 1'b0;
    bit_tick_s = 1'b0;
    if (clr) begin
      os_cnt_s = '0;
    end else if (adv) begin
      if (os_cnt_r == CNT_W'(OVERSAMPLE - 1)) begin
        os_cnt_s   = '0;
        bit_tick_s = 1'b1;
      end else begin
        os_cnt_s   = os_cnt_r + CNT_W'(1);
        mid_tick_s = (os_cnt_s == CNT_W'(OVERSAMPLE / 2));
      end
    end else begin
      os_cnt_s = os_cnt_r;
    end
  end

  // Count and registered tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt_r   <= '0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else begin
      os_cnt_r   <= os_cnt_s;
      mid_tick_r <= mid_tick_s;
      bit_tick_r <= bit_tick_s;
    end
  end

  assign mid_tick = mid_tick_r;
  assign bit_tick = bit_tick_r;

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional UART baud generator: produces oversample, mid-bit and bit
// ticks from a shadowed integer+fraction divisor, with phase resync.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_int,
  input  logic [FRAC_WIDTH-1:0] baud_frac,
  input  logic                  div_load,
  input  logic                  resync,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  bit_tick,
  output logic                  running
);

  baud_state_e           state_r;
  baud_state_e           state_s;
  logic [DIV_WIDTH-1:0]  cyc_cnt_r;
  logic [DIV_WIDTH-1:0]  cyc_cnt_s;
  logic [FRAC_WIDTH-1:0] acc_r;
  logic [FRAC_WIDTH-1:0] acc_s;
  logic                  extra_r;
  logic                  extra_s;
  logic [DIV_WIDTH-1:0]  act_int_r;
  logic [DIV_WIDTH-1:0]  act_int_s;
  logic [FRAC_WIDTH-1:0] act_frac_r;
  logic [FRAC_WIDTH-1:0] act_frac_s;
  logic [DIV_WIDTH-1:0]  shd_int_r;
  logic [DIV_WIDTH-1:0]  shd_int_s;
  logic [FRAC_WIDTH-1:0] shd_frac_r;
  logic [FRAC_WIDTH-1:0] shd_frac_s;
  logic                  os_tick_r;
  logic                  os_tick_s;
  logic                  running_r;
  logic [DIV_WIDTH-1:0]  p_last_s;
  logic [FRAC_WIDTH:0]   frac_sum_s;
  logic                  adv_s;
  logic                  clr_s;

  // Next-state, divisor shadowing and cycle counting.
  always_comb begin
    state_s    = state_r;
    cyc_cnt_s  = cyc_cnt_r;
    acc_s      = acc_r;
    extra_s    = extra_r;
    act_int_s  = act_int_r;
    act_frac_s = act_frac_r;
    shd_int_s  = shd_int_r;
    shd_frac_s = shd_frac_r;
    os_tick_s  = 1'b0;
    adv_s      = 1'b0;
    clr_s      = 1'b0;
    // Last count of the current period; a pending carry stretches it by one.
    // Using act_int (not act_int+1) keeps everything inside DIV_WIDTH bits.
    p_last_s   = extra_r ? act_int_r : (act_int_r - DIV_WIDTH'(1));
    frac_sum_s = {1'b0, acc_r} + {1'b0, act_frac_r};

    case (state_r)
      ST_IDLE: begin
        clr_s     = 1'b1;
        cyc_cnt_s = '0;
        acc_s     = '0;
        extra_s   = 1'b0;
        if (div_load) begin
          shd_int_s  = baud_int;
          shd_frac_s = baud_frac;
          act_int_s  = baud_int;
          act_frac_s = baud_frac;
        end else begin
          shd_int_s  = shd_int_r;
          shd_frac_s = shd_frac_r;
        end
        if (enable && (act_int_r >= DIV_WIDTH'(2))) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Stop overrides any load, resync or tick this cycle.
          state_s   = ST_IDLE;
          clr_s     = 1'b1;
          cyc_cnt_s = '0;
          acc_s     = '0;
          extra_s   = 1'b0;
        end else if (resync) begin
          clr_s     = 1'b1;
          cyc_cnt_s = '0;
          acc_s     = '0;
          extra_s   = 1'b0;
          if (div_load) begin
            // Realignment point is also a safe moment to switch divisor.
            shd_int_s  = baud_int;
            shd_frac_s = baud_frac;
            act_int_s  = baud_int;
            act_frac_s = baud_frac;
            state_s    = (baud_int >= DIV_WIDTH'(2)) ? ST_RUN : ST_IDLE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          if (div_load) begin
            shd_int_s  = baud_int;
            shd_frac_s = baud_frac;
          end else begin
            shd_int_s  = shd_int_r;
            shd_frac_s = shd_frac_r;
          end
          if (cyc_cnt_r == p_last_s) begin
            // Period boundary: swap in the shadow divisor for the next period.
            cyc_cnt_s  = '0;
            act_int_s  = shd_int_s;
            act_frac_s = shd_frac_s;
            if (shd_int_s < DIV_WIDTH'(2)) begin
              state_s = ST_IDLE;
              clr_s   = 1'b1;
              acc_s   = '0;
              extra_s = 1'b0;
            end else begin
              acc_s     = frac_sum_s[FRAC_WIDTH-1:0];
              extra_s   = frac_sum_s[FRAC_WIDTH];
              os_tick_s = 1'b1;
              adv_s     = 1'b1;
            end
          end else begin
            cyc_cnt_s = cyc_cnt_r + DIV_WIDTH'(1);
          end
        end
      end

      default: begin
        state_s   = ST_IDLE;
        clr_s     = 1'b1;
        cyc_cnt_s = '0;
        acc_s     = '0;
        extra_s   = 1'b0;
      end
    endcase
  end

  // State, counters, divisors and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cyc_cnt_r  <= '0;
      acc_r      <= '0;
      extra_r    <= 1'b0;
      act_int_r  <= '0;
      act_frac_r <= '0;
      shd_int_r  <= '0;
      shd_frac_r <= '0;
      os_tick_r  <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cyc_cnt_r  <= cyc_cnt_s;
      acc_r      <= acc_s;
      extra_r    <= extra_s;
      act_int_r  <= act_int_s;
      act_frac_r <= act_frac_s;
      shd_int_r  <= shd_int_s;
      shd_frac_r <= shd_frac_s;
      os_tick_r  <= os_tick_s;
      running_r  <= (state_s == ST_RUN);
    end
  end

  uart_os_prescaler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .adv      (adv_s),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  assign os_tick = os_tick_r;
  assign running = running_r;

endmodule
